// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the two-master memory port arbiter.
// Imported by the arbiter top and its round-robin picker.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

    localparam logic M0 = 1'b0;
    localparam logic M1 = 1'b1;

    localparam int CNT_W = 4;

endpackage

// File: rtl/mem_port_arbiter_rr_arbiter2.sv
// Two-way round-robin pick: a tie goes to the master that did not win last.
// Purely combinational; the owner pointer lives in the arbiter top.
module rr_arbiter2
    import mem_port_arbiter_pkg::*;
(
    input  logic req0,
    input  logic req1,
    input  logic last_grant,
    output logic grant,
    output logic valid
);

    always_comb begin
        grant = M0;
        valid = req0 | req1;
        unique case (1'b1)
            (req0 & req1):  grant = ~last_grant;
            (req0 & ~req1): grant = M0;
            (~req0 & req1): grant = M1;
            default:        grant = M0;
        endcase
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between two masters with round-robin arbitration
// and a fixed number of access cycles per transaction.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              clock,
    input  logic              reset,

    input  logic              m0_req,
    input  logic              m0_rw,
    input  logic [DATA_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_gnt,
    output logic              m0_ack,
    output logic [DATA_W-1:0] m0_rdata,

    input  logic              m1_req,
    input  logic              m1_rw,
    input  logic [DATA_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_gnt,
    output logic              m1_ack,
    output logic [DATA_W-1:0] m1_rdata,

    output logic [DATA_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_datao,
    output logic              mem_rw,
    input  logic [DATA_W-1:0] mem_data,

    output logic              busy
);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES - 1);

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic               owner;
    logic               last_grant;
    logic               lat_rw;
    logic [DATA_W-1:0]  lat_addr;
    logic [DATA_W-1:0]  lat_wdata;

    logic               pick;
    logic               pick_valid;
    logic               in_access;

    rr_arbiter2 u_rr (
        .req0       (m0_req),
        .req1       (m1_req),
        .last_grant (last_grant),
        .grant      (pick),
        .valid      (pick_valid)
    );

    // Memory only ever sees the latched request, and idles as a read of 0.
    assign in_access   = (state == ACCESS);
    assign mem_address = in_access ? lat_addr  : '0;
    assign mem_datao   = in_access ? lat_wdata : '0;
    assign mem_rw      = in_access ? lat_rw    : RW_READ;

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            owner      <= M0;
            last_grant <= M1;
            lat_rw     <= RW_WRITE;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            m0_rdata   <= '0;
            m1_rdata   <= '0;
            m0_gnt     <= 1'b0;
            m1_gnt     <= 1'b0;
            m0_ack     <= 1'b0;
            m1_ack     <= 1'b0;
            busy       <= 1'b0;
        end else begin
            m0_ack <= 1'b0;
            m1_ack <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (pick_valid) begin
                        state      <= ACCESS;
                        cnt        <= CNT_LOAD;
                        owner      <= pick;
                        last_grant <= pick;
                        lat_rw     <= (pick == M1) ? m1_rw    : m0_rw;
                        lat_addr   <= (pick == M1) ? m1_addr  : m0_addr;
                        lat_wdata  <= (pick == M1) ? m1_wdata : m0_wdata;
                        m0_gnt     <= (pick == M0);
                        m1_gnt     <= (pick == M1);
                        busy       <= 1'b1;
                    end
                end
                ACCESS: begin
                    if (cnt == '0) begin
                        state <= RESP;
                        if (lat_rw == RW_READ) begin
                            if (owner == M1) begin
                                m1_rdata <= mem_data;
                            end else begin
                                m0_rdata <= mem_data;
                            end
                        end
                        m0_ack <= (owner == M0);
                        m1_ack <= (owner == M1);
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                RESP: begin
                    state  <= IDLE;
                    m0_gnt <= 1'b0;
                    m1_gnt <= 1'b0;
                    busy   <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Random two-master traffic against a timeline model of the shared port,
// run at one and at three access cycles per transaction.
module tb_mem_port_arbiter;

    localparam int NCYC = 700;

    logic clk;
    int   vectors = 0;
    int   errors  = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] memfn(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    for (genvar gi = 0; gi < 2; gi++) begin : gb
        localparam int W = (gi == 0) ? 1 : 3;

        logic        rst;
        logic [1:0]  req;
        logic [1:0]  rw;
        logic [31:0] addr [2];
        logic [31:0] wd [2];
        logic        g0, g1, a0, a1, mrw, busy;
        logic [31:0] r0, r1, maddr, mdo, mdi;
        bit          done = 1'b0;

        assign mdi = memfn(maddr);

        mem_port_arbiter #(.DATA_W(32), .WAIT_CYCLES(W)) dut (
            .clock       (clk),
            .reset       (rst),
            .m0_req      (req[0]),
            .m0_rw       (rw[0]),
            .m0_addr     (addr[0]),
            .m0_wdata    (wd[0]),
            .m0_gnt      (g0),
            .m0_ack      (a0),
            .m0_rdata    (r0),
            .m1_req      (req[1]),
            .m1_rw       (rw[1]),
            .m1_addr     (addr[1]),
            .m1_wdata    (wd[1]),
            .m1_gnt      (g1),
            .m1_ack      (a1),
            .m1_rdata    (r1),
            .mem_address (maddr),
            .mem_datao   (mdo),
            .mem_rw      (mrw),
            .mem_data    (mdi),
            .busy        (busy)
        );

        initial begin
            bit          act, own, last, lrw, ea, er, eb;
            int          k, ge, nf, p;
            logic [31:0] la, lw;
            logic [31:0] rd [2];
            string       pre;

            pre = $sformatf("w%0d.", W);
            rst = 1'b1;
            req = '0;
            rw  = '0;
            addr[0] = '0; addr[1] = '0;
            wd[0] = '0;   wd[1] = '0;
            k = -1; ge = 0; nf = 0;
            act = 0; own = 0; last = 1; lrw = 1;
            la = '0; lw = '0;
            rd[0] = '0; rd[1] = '0;

            for (int c = 0; c < NCYC; c++) begin
                @(posedge clk);
                k++;
                // Port timeline: grant at edge ge, W access cycles, one ack
                // cycle, one idle cycle, next grant no earlier than ge+W+2.
                if (rst) begin
                    act = 0;
                    last = 1;
                    rd[0] = '0;
                    rd[1] = '0;
                    nf = k + 1;
                end else begin
                    if (act && k == ge + W && lrw)
                        rd[own] = memfn(la);
                    if (k >= nf && req != 2'b00) begin
                        own  = (req == 2'b11) ? !last : req[1];
                        last = own;
                        act  = 1;
                        ge   = k;
                        lrw  = rw[own];
                        la   = addr[own];
                        lw   = wd[own];
                        nf   = k + W + 2;
                    end
                end

                @(negedge clk);
                ea = act && k >= ge && k < ge + W;
                er = act && k == ge + W;
                eb = ea || er;
                chk({pre, "busy"},  32'(busy), 32'(eb));
                chk({pre, "gnt0"},  32'(g0), 32'(eb && own == 0));
                chk({pre, "gnt1"},  32'(g1), 32'(eb && own == 1));
                chk({pre, "ack0"},  32'(a0), 32'(er && own == 0));
                chk({pre, "ack1"},  32'(a1), 32'(er && own == 1));
                chk({pre, "mem_rw"},   32'(mrw), 32'(ea ? lrw : 1'b1));
                chk({pre, "mem_addr"}, maddr, ea ? la : 32'h0);
                chk({pre, "mem_dout"}, mdo, ea ? lw : 32'h0);
                chk({pre, "rdata0"}, r0, rd[0]);
                chk({pre, "rdata1"}, r1, rd[1]);

                // Second half: both masters re-request at once, forcing ties.
                p = (c < NCYC / 2) ? 40 : 100;
                for (int i = 0; i < 2; i++) begin
                    if (er && own == i) begin
                        req[i] = 1'b0;
                    end else if (req[i] && eb && own == i) begin
                        rw[i]   = 1'($urandom);
                        addr[i] = $urandom;
                        wd[i]   = $urandom;
                    end else if (!req[i] && $urandom_range(0, 99) < p) begin
                        req[i]  = 1'b1;
                        rw[i]   = 1'($urandom);
                        addr[i] = ($urandom_range(0, 3) == 0) ?
                                  32'($urandom_range(0, 255)) : $urandom;
                        wd[i]   = $urandom;
                    end
                end
                rst = (c < 2) ||
                      ($urandom_range(0, (c < NCYC / 2) ? 39 : 99) == 0);
            end
            done = 1'b1;
        end
    end

    initial begin
        for (int t = 0; t < NCYC + 50; t++) begin
            if (gb[0].done && gb[1].done) break;
            @(posedge clk);
        end
        if (!(gb[0].done && gb[1].done))
            chk("timeout", 32'(gb[0].done && gb[1].done), 32'd1);
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, errors);
        $finish;
    end

endmodule
